// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Optional feature macro used by the top: SEQ_DETECT_MATCH_CNT_EN.
package seq_detect_pkg;

    localparam int MIN_LEN         = 1;
    localparam int DEFAULT_MAX_LEN = 8;

    function automatic int len_w(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/seq_detect_prog_cmp.sv
// Combinational masked comparison of candidate history against the pattern.
// Only the low pat_len bits take part; an out-of-range length never matches.
module seq_match_cmp
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] i_hist,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]   i_pat_len,
    output logic               o_match,
    output logic               o_cfg_valid
);

    logic [MAX_LEN-1:0] w_mask;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i_pat_len > LEN_W'(i));
        end
    end

    assign o_cfg_valid = (i_pat_len >= LEN_W'(MIN_LEN)) &&
                         (i_pat_len <= LEN_W'(MAX_LEN));

    assign o_match = o_cfg_valid &&
                     (((i_hist ^ i_pattern) & w_mask) == '0);

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with overlap control and match pulse.
// Define SEQ_DETECT_MATCH_CNT_EN to build the saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int LEN_W   = len_w(MAX_LEN),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_valid,
    input  logic               inp_bit,
    input  logic               clear,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap_en,
    output logic               seq_seen,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_count
);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_seen;
    logic               r_err;

    logic [MAX_LEN-1:0] w_hist_shift;
    logic [MAX_LEN-1:0] w_hist_d;
    logic [LEN_W-1:0]   w_fill_d;
    logic [LEN_W:0]     w_fill_inc;
    logic               w_seen_d;
    logic               w_cmp_match;
    logic               w_cfg_valid;
    logic               w_len_ok;
    logic               w_hit;

    assign w_hist_shift = {r_hist[MAX_LEN-2:0], inp_bit};
    assign w_fill_inc   = {1'b0, r_fill} + (LEN_W+1)'(1);
    assign w_len_ok     = (w_fill_inc >= {1'b0, pat_len});

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .i_hist      (w_hist_shift),
        .i_pattern   (pattern),
        .i_pat_len   (pat_len),
        .o_match     (w_cmp_match),
        .o_cfg_valid (w_cfg_valid)
    );

    assign w_hit = inp_valid && w_cmp_match && w_len_ok;

    always_comb begin
        w_hist_d = r_hist;
        w_fill_d = r_fill;
        w_seen_d = 1'b0;
        if (clear) begin
            w_hist_d = '0;
            w_fill_d = '0;
        end else if (inp_valid) begin
            w_hist_d = w_hist_shift;
            w_seen_d = w_hit;
            // Non-overlapping mode restarts the fill so suffix bits are not reused
            if (w_hit && !overlap_en) begin
                w_fill_d = '0;
            end else if (r_fill == LEN_W'(MAX_LEN)) begin
                w_fill_d = r_fill;
            end else begin
                w_fill_d = w_fill_inc[LEN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_seen <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_hist <= w_hist_d;
            r_fill <= w_fill_d;
            r_seen <= w_seen_d;
            r_err  <= !w_cfg_valid;
        end
    end

    assign seq_seen = r_seen;
    assign cfg_err  = r_err;

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count;
        if (clear) begin
            w_count_d = '0;
        end else if (w_seen_d && (r_count != {CNT_W{1'b1}})) begin
            w_count_d = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

    assign match_count = r_count;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed table-driven bench for seq_detect_prog (MAX_LEN=8, CNT_W=2).
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               inp_valid = 1'b0;
    logic               inp_bit = 1'b0;
    logic               clear = 1'b0;
    logic [MAX_LEN-1:0] pattern = '0;
    logic [LEN_W-1:0]   pat_len = '0;
    logic               overlap_en = 1'b0;
    logic               seq_seen;
    logic               cfg_err;
    logic [CNT_W-1:0]   match_count;

    seq_detect_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inp_valid   (inp_valid),
        .inp_bit     (inp_bit),
        .clear       (clear),
        .pattern     (pattern),
        .pat_len     (pat_len),
        .overlap_en  (overlap_en),
        .seq_seen    (seq_seen),
        .cfg_err     (cfg_err),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       v;
        logic       b;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       seen;
        logic       err;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step    = 0;
    int   cnt_m   = 0;

    function automatic vec_t mk(input int rst, input int clr, input int v,
                                input int b, input int pat, input int len,
                                input int ovl, input int seen, input int err);
        vec_t t;
        t.rst  = 1'(rst);
        t.clr  = 1'(clr);
        t.v    = 1'(v);
        t.b    = 1'(b);
        t.pat  = 8'(pat);
        t.len  = 4'(len);
        t.ovl  = 1'(ovl);
        t.seen = 1'(seen);
        t.err  = 1'(err);
        return t;
    endfunction

    function automatic void add(input int rst, input int clr, input int v,
                                input int b, input int pat, input int len,
                                input int ovl, input int seen, input int err);
        vq.push_back(mk(rst, clr, v, b, pat, len, ovl, seen, err));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d",
                     nm, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        int exp_cnt;
        @(negedge clk);
        reset      = t.rst;
        clear      = t.clr;
        inp_valid  = t.v;
        inp_bit    = t.b;
        pattern    = t.pat;
        pat_len    = t.len;
        overlap_en = t.ovl;
        @(posedge clk);
        #1;
        if (t.rst || t.clr) cnt_m = 0;
        else if (t.seen && cnt_m != 3) cnt_m++;
`ifdef SEQ_DETECT_MATCH_CNT_EN
        exp_cnt = cnt_m;
`else
        exp_cnt = 0;
`endif
        chk("seq_seen", int'(seq_seen), int'(t.seen));
        chk("cfg_err", int'(cfg_err), int'(t.err));
        chk("match_count", int'(match_count), exp_cnt);
        step++;
    endtask

    initial begin
        logic [6:0] sb;
        logic [6:0] se;
        sb = 7'b1011011;
        se = 7'b0001001;

        // reset state
        add(1, 0, 0, 0, 'h0B, 4, 1, 0, 0);
        // overlapping 1011 on 1011011
        for (int i = 0; i < 7; i++)
            add(0, 0, 1, int'(sb[6-i]), 'h0B, 4, 1, int'(se[6-i]), 0);
        add(0, 1, 0, 0, 'h0B, 4, 0, 0, 0);
        // non-overlapping: only the first match
        for (int i = 0; i < 7; i++)
            add(0, 0, 1, int'(sb[6-i]), 'h0B, 4, 0, (i == 3) ? 1 : 0, 0);
        add(0, 1, 0, 0, 'h0B, 4, 1, 0, 0);
        // gaps of three idle cycles between bits
        for (int i = 0; i < 7; i++) begin
            add(0, 0, 1, int'(sb[6-i]), 'h0B, 4, 1, int'(se[6-i]), 0);
            for (int g = 0; g < 3; g++)
                add(0, 0, 0, 0, 'h0B, 4, 1, 0, 0);
        end
        // reset mid-stream clears history and fill
        add(0, 1, 0, 0, 'h0B, 4, 1, 0, 0);
        add(0, 0, 1, 1, 'h0B, 4, 1, 0, 0);
        add(0, 0, 1, 0, 'h0B, 4, 1, 0, 0);
        add(0, 0, 1, 1, 'h0B, 4, 1, 0, 0);
        add(1, 0, 0, 0, 'h0B, 4, 1, 0, 0);
        add(0, 0, 1, 1, 'h0B, 4, 1, 0, 0);
        add(0, 0, 1, 1, 'h03, 4, 1, 0, 0);
        add(0, 0, 1, 0, 'h03, 4, 1, 0, 0);
        add(0, 0, 1, 0, 'h03, 4, 1, 0, 0);
        add(0, 0, 1, 1, 'h03, 4, 1, 0, 0);
        add(0, 0, 1, 1, 'h03, 4, 1, 1, 0);
        // invalid lengths 0 and 9
        add(0, 1, 0, 0, 'h0B, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++)
            add(0, 0, 1, int'(sb[6-i]), 'h0B, 0, 1, 0, 1);
        add(0, 0, 0, 0, 'h0B, 9, 1, 0, 1);
        for (int i = 0; i < 4; i++)
            add(0, 0, 1, int'(sb[6-i]), 'h0B, 9, 1, 0, 1);
        // single-bit pattern
        add(0, 1, 0, 0, 'h01, 1, 1, 0, 0);
        add(0, 0, 1, 1, 'h01, 1, 1, 1, 0);
        add(0, 0, 1, 1, 'h01, 1, 1, 1, 0);
        add(0, 0, 1, 0, 'h01, 1, 1, 0, 0);
        add(0, 0, 1, 1, 'h01, 1, 0, 1, 0);
        add(0, 0, 1, 1, 'h01, 1, 0, 1, 0);

        foreach (vq[k]) apply(vq[k]);

        // counter saturation and clear racing a valid bit
        apply(mk(0, 1, 0, 0, 'h01, 1, 1, 0, 0));
        for (int i = 0; i < 5; i++)
            apply(mk(0, 0, 1, 1, 'h01, 1, 1, 1, 0));
        apply(mk(0, 1, 1, 1, 'h01, 1, 1, 0, 0));
        apply(mk(0, 0, 0, 0, 'h01, 1, 1, 0, 0));
        apply(mk(0, 0, 1, 1, 'h01, 1, 1, 1, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
